// File: rtl/matmul_operand_loader.sv
`default_nettype none
// matmul_operand_loader: drives operand pairs into a 2x2 matmul tile for a fixed
// latency window, then captures, self-checks and presents the packed result.
module matmul_operand_loader #(
   parameter int LATENCY = 2,
   parameter int GAP     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic        mm_ena,
   output logic [7:0]  mm_ui_in,
   output logic [7:0]  mm_uio_in,
   input  logic [7:0]  mm_uo_out,
   input  logic [7:0]  mm_uio_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_c,
   output logic        res_err,
   output logic [7:0]  frame_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam logic [3:0] C_LAT    = 4'(LATENCY);
   localparam logic [3:0] C_GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_timer;
   logic        r_in_ready;
   logic        r_mm_ena;
   logic [7:0]  r_ui_in;
   logic [7:0]  r_uio_in;
   logic        r_res_valid;
   logic [15:0] r_res_c;
   logic        r_res_err;
   logic [7:0]  r_frame_cnt;
   logic        w_run_last;
   logic        w_res_hs;
   logic [15:0] w_c_exp;

   function automatic logic [3:0] f_sx(input logic [1:0] v);
      return {{2{v[1]}}, v};
   endfunction

   // 4-bit wrapping dot product of a matrix row with a matrix column
   function automatic logic [3:0] f_dot(input logic [1:0] x0, input logic [1:0] x1,
                                        input logic [1:0] y0, input logic [1:0] y1);
      return f_sx(x0) * f_sx(y0) + f_sx(x1) * f_sx(y1);
   endfunction

   assign w_c_exp = {f_dot(r_ui_in[5:4], r_ui_in[7:6], r_uio_in[3:2], r_uio_in[7:6]),
                     f_dot(r_ui_in[5:4], r_ui_in[7:6], r_uio_in[1:0], r_uio_in[5:4]),
                     f_dot(r_ui_in[1:0], r_ui_in[3:2], r_uio_in[3:2], r_uio_in[7:6]),
                     f_dot(r_ui_in[1:0], r_ui_in[3:2], r_uio_in[1:0], r_uio_in[5:4])};

   assign w_run_last = (r_state == S_RUN) && (r_timer == 4'd0);
   assign w_res_hs   = (r_state == S_HOLD) && res_ready;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (in_valid)   w_state_nxt = S_RUN;
         S_RUN:  if (w_run_last) w_state_nxt = S_HOLD;
         S_HOLD: if (res_ready)  w_state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
         S_GAP:  if (r_timer == 4'd0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer     <= 4'd0;
         r_in_ready  <= 1'b1;
         r_mm_ena    <= 1'b0;
         r_ui_in     <= 8'd0;
         r_uio_in    <= 8'd0;
         r_res_valid <= 1'b0;
         r_res_c     <= 16'd0;
         r_res_err   <= 1'b0;
         r_frame_cnt <= 8'd0;
      end else begin
         r_in_ready  <= (w_state_nxt == S_IDLE);
         r_mm_ena    <= (w_state_nxt == S_RUN);
         r_res_valid <= (w_state_nxt == S_HOLD);
         // operands are latched on entry to RUN and zeroed whenever the tile is idle
         if (w_state_nxt == S_RUN) begin
            if (r_state == S_IDLE) begin
               r_ui_in  <= in_a;
               r_uio_in <= in_b;
            end
         end else begin
            r_ui_in  <= 8'd0;
            r_uio_in <= 8'd0;
         end
         case (r_state)
            S_IDLE:       r_timer <= C_LAT;
            S_HOLD:       r_timer <= C_GAP_M1;
            S_RUN, S_GAP: if (r_timer != 4'd0) r_timer <= r_timer - 4'd1;
            default:      r_timer <= 4'd0;
         endcase
         if (w_run_last) begin
            r_res_c   <= {mm_uio_out, mm_uo_out};
            r_res_err <= ({mm_uio_out, mm_uo_out} != w_c_exp);
         end
         if (w_res_hs) r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   assign in_ready  = r_in_ready;
   assign mm_ena    = r_mm_ena;
   assign mm_ui_in  = r_ui_in;
   assign mm_uio_in = r_uio_in;
   assign res_valid = r_res_valid;
   assign res_c     = r_res_c;
   assign res_err   = r_res_err;
   assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_matmul_operand_loader.sv
`default_nettype none
// tb_matmul_operand_loader: scoreboard bench with a behavioural matmul tile model.
module tb_matmul_operand_loader;

   localparam int LATENCY = 2;
   localparam int GAP     = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        mm_ena;
   logic [7:0]  mm_ui_in;
   logic [7:0]  mm_uio_in;
   logic [7:0]  mm_uo_out;
   logic [7:0]  mm_uio_out;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_c;
   logic        res_err;
   logic [7:0]  frame_cnt;

   logic        force_zero = 1'b0;
   logic [16:0] sbq[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   matmul_operand_loader #(.LATENCY(LATENCY), .GAP(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mm_ena     (mm_ena),
      .mm_ui_in   (mm_ui_in),
      .mm_uio_in  (mm_uio_in),
      .mm_uo_out  (mm_uo_out),
      .mm_uio_out (mm_uio_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_c      (res_c),
      .res_err    (res_err),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mm_model(input logic [7:0] a, input logic [7:0] b);
      int ae[2][2];
      int be[2][2];
      int s;
      logic signed [1:0] t;
      logic [15:0] r;
      r = 16'h0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            t = a[2*(2*i+j) +: 2]; ae[i][j] = t;
            t = b[2*(2*i+j) +: 2]; be[i][j] = t;
         end
      end
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            s = ae[i][0] * be[0][j] + ae[i][1] * be[1][j];
            r[4*(2*i+j) +: 4] = 4'(s & 15);
         end
      end
      return r;
   endfunction

   always_comb begin
      {mm_uio_out, mm_uo_out} = 16'h0;
      if (mm_ena && !force_zero) {mm_uio_out, mm_uo_out} = mm_model(mm_ui_in, mm_uio_in);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_a = 8'h0; in_b = 8'h0; res_ready = 1'b1;
      repeat (3) tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (mm_ena !== 1'b0) begin bad++; $display("FAIL reset_mm_ena got=%b exp=0", mm_ena); end
      total++; if ({mm_ui_in, mm_uio_in} !== 16'h0) begin bad++; $display("FAIL reset_operands got=%h exp=0", {mm_ui_in, mm_uio_in}); end
      total++; if ({res_valid, res_err, res_c} !== 18'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", {res_valid, res_err, res_c}); end
      total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [16:0] e;
      res_ready = 1'b1;
      in_valid = 1'b1; in_a = 8'h55; in_b = 8'h55;
      sbq.push_back({1'b0, mm_model(8'h55, 8'h55)});
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= LATENCY + 1; k++) begin
         total++;
         if ({mm_ena, mm_ui_in, mm_uio_in, in_ready, res_valid} !== {1'b1, 8'h55, 8'h55, 1'b0, 1'b0}) begin
            bad++; $display("FAIL basic_run_cycle%0d got ena=%b ui=%h uio=%h rdy=%b vld=%b exp ena=1 ui=55 uio=55 rdy=0 vld=0",
                            k, mm_ena, mm_ui_in, mm_uio_in, in_ready, res_valid);
         end
         tick();
      end
      total++; if (res_valid !== 1'b1 || mm_ena !== 1'b0) begin bad++; $display("FAIL basic_hold got vld=%b ena=%b exp vld=1 ena=0", res_valid, mm_ena); end
      e = (sbq.size() > 0) ? sbq.pop_front() : 17'h1ffff;
      total++; if (res_c !== e[15:0] || res_c !== 16'h2222) begin bad++; $display("FAIL basic_res_c got=%h exp=2222", res_c); end
      total++; if (res_err !== 1'b0) begin bad++; $display("FAIL basic_res_err got=%b exp=0", res_err); end
      tick();
      total++; if (frame_cnt !== 8'd1 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
         bad++; $display("FAIL basic_gap got cnt=%0d rdy=%b vld=%b exp cnt=1 rdy=0 vld=0", frame_cnt, in_ready, res_valid);
      end
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_again got=%b exp=1", in_ready); end
   endtask

   task automatic frame_check(input string nm, input logic [7:0] a, input logic [7:0] b,
                              input logic fz, input logic [15:0] spec_c, input logic spec_err);
      int n;
      logic [15:0] pc;
      logic [16:0] e;
      force_zero = fz;
      res_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 30) begin tick(); n++; end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_accept_timeout got rdy=%b exp=1", nm, in_ready); end
      in_valid = 1'b1; in_a = a; in_b = b;
      pc = fz ? 16'h0 : mm_model(a, b);
      sbq.push_back({(pc !== mm_model(a, b)), pc});
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 30) begin tick(); n++; end
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL %s_result_timeout got vld=%b exp=1", nm, res_valid); end
      e = (sbq.size() > 0) ? sbq.pop_front() : 17'h1ffff;
      total++; if (res_c !== e[15:0]) begin bad++; $display("FAIL %s_sb_res_c got=%h exp=%h", nm, res_c, e[15:0]); end
      total++; if (res_err !== e[16]) begin bad++; $display("FAIL %s_sb_res_err got=%b exp=%b", nm, res_err, e[16]); end
      total++; if (res_c !== spec_c || res_err !== spec_err) begin
         bad++; $display("FAIL %s_const got c=%h err=%b exp c=%h err=%b", nm, res_c, res_err, spec_c, spec_err);
      end
      tick();
      force_zero = 1'b0;
   endtask

   task automatic test_signs();
      frame_check("neg", 8'hFF, 8'h55, 1'b0, 16'hEEEE, 1'b0);
      frame_check("ovf", 8'hAA, 8'hAA, 1'b0, 16'h8888, 1'b0);
   endtask

   task automatic test_mismatch();
      frame_check("mismatch", 8'h55, 8'h55, 1'b1, 16'h0000, 1'b1);
   endtask

   task automatic test_backpressure();
      int n;
      logic [7:0] cnt0;
      logic [16:0] e;
      n = 0;
      while (!in_ready && n < 30) begin tick(); n++; end
      cnt0 = frame_cnt;
      res_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hF5;
      sbq.push_back({1'b0, mm_model(8'h5A, 8'hF5)});
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 30) begin tick(); n++; end
      e = (sbq.size() > 0) ? sbq.pop_front() : 17'h1ffff;
      for (int k = 0; k < 6; k++) begin
         total++;
         if ({res_valid, res_c, res_err, in_ready, mm_ena} !== {1'b1, e[15:0], e[16], 1'b0, 1'b0}) begin
            bad++; $display("FAIL bp_hold%0d got vld=%b c=%h err=%b rdy=%b ena=%b exp vld=1 c=%h err=%b rdy=0 ena=0",
                            k, res_valid, res_c, res_err, in_ready, mm_ena, e[15:0], e[16]);
         end
         if (k == 5) res_ready = 1'b1;
         tick();
      end
      total++; if (frame_cnt !== cnt0 + 8'd1 || res_valid !== 1'b0) begin
         bad++; $display("FAIL bp_handshake got cnt=%0d vld=%b exp cnt=%0d vld=0", frame_cnt, res_valid, cnt0 + 8'd1);
      end
      repeat (3) tick();
      total++; if (frame_cnt !== cnt0 + 8'd1) begin bad++; $display("FAIL bp_single_inc got=%0d exp=%0d", frame_cnt, cnt0 + 8'd1); end
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      while (!in_ready && n < 30) begin tick(); n++; end
      res_ready = 1'b1;
      in_valid = 1'b1; in_a = 8'h55; in_b = 8'h55;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if ({mm_ena, in_ready, res_valid} !== 3'b010 || frame_cnt !== 8'd0) begin
         bad++; $display("FAIL midreset got ena=%b rdy=%b vld=%b cnt=%0d exp ena=0 rdy=1 vld=0 cnt=0", mm_ena, in_ready, res_valid, frame_cnt);
      end
      frame_check("after_reset", 8'h55, 8'hFF, 1'b0, 16'hEEEE, 1'b0);
   endtask

   task automatic test_back_to_back();
      int accepts, results, last_acc, n;
      logic acc, hs;
      logic [16:0] e;
      rst = 1'b1; tick(); rst = 1'b0;
      res_ready = 1'b1;
      accepts = 0; results = 0; last_acc = -1; n = 0;
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      while (results < 256 && n < 256 * 6 + 50) begin
         acc = in_valid && in_ready;
         hs  = res_valid && res_ready;
         if (acc) begin
            sbq.push_back({1'b0, mm_model(in_a, in_b)});
            if (last_acc >= 0) begin
               total++; if (cyc - last_acc != LATENCY + 3 + GAP) begin
                  bad++; $display("FAIL b2b_period got=%0d exp=%0d", cyc - last_acc, LATENCY + 3 + GAP);
               end
            end
            last_acc = cyc;
            accepts++;
         end
         if (hs) begin
            e = (sbq.size() > 0) ? sbq.pop_front() : 17'h1ffff;
            total++; if ({res_err, res_c} !== e) begin
               bad++; $display("FAIL b2b_result%0d got err=%b c=%h exp err=%b c=%h", results, res_err, res_c, e[16], e[15:0]);
            end
            results++;
         end
         tick();
         n++;
         if (acc) begin
            if (accepts >= 256) in_valid = 1'b0;
            in_a = 8'($urandom); in_b = 8'($urandom);
         end
      end
      in_valid = 1'b0;
      total++; if (results != 256) begin bad++; $display("FAIL b2b_timeout got=%0d exp=256", results); end
      total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL b2b_wrap got=%0d exp=0", frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_mismatch();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/matmul_operand_loader.md
Name: matmul_operand_loader

Overview:
Host-side transmitter for the 2x2 matrix-multiplier tile. It accepts one packed operand pair (matrix A, matrix B) per valid/ready handshake and drives it onto the multiplier's ui_in/uio_in with ena held high for a fixed latency window. It then captures the packed result C from uo_out/uio_out and presents it on a valid/ready result port. It also checks C against an internally computed product.

Parameters:
LATENCY, 2, multiplier cycles from first operand cycle to result valid on its outputs (1..15)
GAP, 1, idle cycles with mm_ena low between frames (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  loader can accept operands
in_a  in  8  matrix A packed: a00[1:0] a01[3:2] a10[5:4] a11[7:6], 2-bit two's complement
in_b  in  8  matrix B, same packing
mm_ena  out  1  multiplier enable
mm_ui_in  out  8  matrix A to multiplier
mm_uio_in  out  8  matrix B to multiplier
mm_uo_out  in  8  C low byte: c00[3:0] c01[7:4]
mm_uio_out  in  8  C high byte: c10[3:0] c11[7:4]
res_valid  out  1  captured result valid
res_ready  in  1  result consumer ready
res_c  out  16  {mm_uio_out, mm_uo_out} as captured
res_err  out  1  captured C differs from expected product; qualified by res_valid
frame_cnt  out  8  completed result handshakes, wraps 255->0

Behaviour:
- Reset, synchronous on rst=1: state IDLE; in_ready=1; mm_ena=0; mm_ui_in=mm_uio_in=0; res_valid=0; res_c=0; res_err=0; frame_cnt=0. Reset in any state, including mid-frame, aborts the frame with no result.
- States: IDLE, RUN, HOLD, GAP.
- IDLE: in_ready=1. When in_valid&in_ready, latch A and B, load the timer with LATENCY, and go to RUN. If in_valid is low, nothing is latched.
- RUN: mm_ena=1, mm_ui_in=A, mm_uio_in=B, all registered. The state lasts exactly LATENCY+1 cycles. On the last RUN cycle, sample mm_uo_out/mm_uio_out into res_c and go to HOLD. Example: accept at cycle 0, mm_ena high in cycles 1..LATENCY+1, res_valid high from cycle LATENCY+2.
- HOLD: res_valid=1, mm_ena=0, operand outputs are 0. res_c and res_err stay stable until res_valid&res_ready. On that handshake, increment frame_cnt (8-bit wrap) and go to GAP. If GAP=0, go directly to IDLE.
- GAP: all multiplier outputs are 0 for GAP cycles, then the block returns to IDLE.
- in_ready=0 in RUN, HOLD and GAP. in_valid is ignored in those states; the source must hold its data.
- Expected-product check: for each element, cij = ai0*b0j + ai1*b1j. Operands are sign-extended to 4 bits, and products and sums are taken modulo 16 (4-bit wrap, so (-2)(-2)+(-2)(-2)=8 appears as 4'h8). The four expected nibbles are packed like res_c. res_err=1 if any nibble differs. It is registered together with res_c.
- mm_ena is never high outside RUN.
- Minimum frame period with res_ready held high: LATENCY+3+GAP cycles (1 IDLE, LATENCY+1 RUN, 1 HOLD, GAP).

Test Plan:
- Basic: LATENCY=2, GAP=1, res_ready=1, in_a=8'h55, in_b=8'h55, bench multiplier model correct -> mm_ena high cycles 1-3 with mm_ui_in=mm_uio_in=8'h55; res_valid at cycle 4; res_c=16'h2222; res_err=0; frame_cnt=1; in_ready high again at cycle 6.
- Signs and overflow: in_a=8'hFF, in_b=8'h55 -> res_c=16'hEEEE, res_err=0. Then in_a=in_b=8'hAA -> res_c=16'h8888, res_err=0.
- Mismatch detection: model forced to return 16'h0000 for A=B=8'h55 -> res_c=16'h0000, res_err=1.
- Backpressure: res_ready low for 5 cycles after res_valid rises -> res_valid, res_c and res_err stable; in_ready=0; mm_ena=0. Handshake on the 6th cycle -> frame_cnt increments once.
- Reset mid-frame: assert rst in the second RUN cycle -> next cycle mm_ena=0, in_ready=1, res_valid=0, frame_cnt=0. A new in_a=8'h55/in_b=8'hFF frame then completes with res_c=16'hEEEE.
- Counter wrap and throughput: 256 back-to-back frames with in_valid and res_ready held high -> frame_cnt reads 0. Consecutive accepts are exactly LATENCY+3+GAP=6 cycles apart.
